mult_share_arbiter: RTL and testbench

//  Shares one sequential signed multiplier (booth_multiplier-style: start pulse in, done level out)

---
 rtl/mult_share_arbiter.sv | 145 ++++++++++++++
 tb/tb_mult_share_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
// Shares one sequential signed multiplier between two requesters. The multiplier
// takes a start pulse and reports completion with a done level. Requests are
// granted round-robin, so a requester that has just been served loses the next tie.
// The operands are held on mul_M/mul_Q for the whole operation. The product is
// returned as a held response tagged with the winner's id. A watchdog aborts an
// operation whose multiplier never reports done, and that response carries rsp_err.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   reqN_valid/ready/a/b     requester N (N = 0, 1) issue port; ready is combinational
//   mul_start                one-cycle start pulse to the shared multiplier
//   mul_M, mul_Q             operands to the multiplier, stable while it works
//   mul_done, mul_result     multiplier done level and 2*WIDTH signed product
//   rsp_valid/ready          response handshake
//   rsp_id, rsp_result,
//   rsp_err                  winner id, product (0 on abort), watchdog abort flag
//   busy                     high whenever the arbiter is not idle
module mult_share_arbiter #(
    parameter int WIDTH       = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_M,
    output logic [WIDTH-1:0]     mul_Q,
    input  logic                 mul_done,
    input  logic [2*WIDTH-1:0]   mul_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [2*WIDTH-1:0]   rsp_result,
    output logic                 rsp_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

    state_t           state;
    logic             last_grant;
    logic             done_armed;
    logic [CNT_W-1:0] wd_cnt;
    logic             grant0;
    logic             grant1;

    // Grants are combinational so the requester sees ready in the same cycle it
    // is accepted. Gating with rst keeps ready low while reset is asserted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst && state == S_IDLE) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant;
                grant1 = ~last_grant;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            done_armed <= 1'b0;
            wd_cnt     <= '0;
            mul_start  <= 1'b0;
            mul_M      <= '0;
            mul_Q      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant0 || grant1) begin
                        mul_M     <= grant1 ? req1_a : req0_a;
                        mul_Q     <= grant1 ? req1_b : req0_b;
                        rsp_id    <= grant1;
                        mul_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    mul_start  <= 1'b0;
                    wd_cnt     <= '0;
                    done_armed <= 1'b0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    // A done level left over from the previous operation is ignored
                    // until the multiplier has been seen to drop done once.
                    if (!mul_done) begin
                        done_armed <= 1'b1;
                    end
                    if (done_armed && mul_done) begin
                        rsp_result <= mul_result;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        state      <= S_RESP;
                    end else if (wd_cnt == CNT_LAST) begin
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                        rsp_valid  <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        last_grant <= rsp_id;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter
// Scoreboard bench for mult_share_arbiter. The requesters are queues of pending
// operations. A reference arbiter decides which requester should win, and it pushes
// the expected response when the grant happens. A monitor pops and compares each
// response at its handshake. A behavioural multiplier with random latency stands in
// for the shared multiplier. It sometimes holds done high from the previous
// operation for a while, and it can be told to hang.
module tb_mult_share_arbiter;

    localparam int WIDTH       = 32;
    localparam int TIMEOUT_CYC = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WIDTH-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic               mul_start, mul_done;
    logic [WIDTH-1:0]   mul_M, mul_Q;
    logic [2*WIDTH-1:0] mul_result, rsp_result;
    logic               rsp_valid, rsp_ready, rsp_id, rsp_err, busy;

    mult_share_arbiter #(.WIDTH(WIDTH), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .mul_start(mul_start), .mul_M(mul_M), .mul_Q(mul_Q),
        .mul_done(mul_done), .mul_result(mul_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
    );

    typedef struct { int a; int b; bit hang; } op_t;
    typedef struct { bit id; longint prod; bit err; int a; int b; } exp_t;

    op_t  q0[$], q1[$];
    exp_t sb[$];

    int n_chk = 0, n_fail = 0;
    int n_start = 0, n_grant = 0;
    bit m_idle = 1'b1, m_last = 1'b1, m_id = 1'b0, hang_cur = 1'b0;
    int rdy_mode = 0;

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural shared multiplier
    logic signed [63:0] m_prod;
    logic               m_busy;
    int                 m_cnt, m_stale;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_done <= 1'b0; mul_result <= '0; m_busy <= 1'b0;
            m_cnt <= 0; m_stale <= 0; m_prod <= '0;
        end else if (mul_start) begin
            m_busy  <= 1'b1;
            m_cnt   <= $urandom_range(1, 6);
            m_stale <= $urandom_range(0, 2);
            m_prod  <= longint'($signed(mul_M)) * longint'($signed(mul_Q));
        end else if (m_busy) begin
            if (m_stale > 0) begin
                m_stale <= m_stale - 1;
            end else begin
                mul_done <= 1'b0;
                if (m_cnt == 0) begin
                    m_busy <= 1'b0;
                    if (!hang_cur) begin
                        mul_done   <= 1'b1;
                        mul_result <= m_prod;
                    end
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    // Requesters + reference arbiter
    initial begin : engine
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b1;
        forever begin
            bit   e0, e1, hs;
            op_t  o;
            exp_t x;
            @(negedge clk);
            e0 = 1'b0; e1 = 1'b0;
            chk("busy", busy, !m_idle);
            if (rst && m_idle && (req0_valid || req1_valid)) begin
                // Sole requester wins; on a tie the one not served last wins.
                if (req0_valid && req1_valid) begin
                    if (m_last) e0 = 1'b1; else e1 = 1'b1;
                end else if (req0_valid) e0 = 1'b1;
                else e1 = 1'b1;
            end
            chk("req0_ready", req0_ready, e0);
            chk("req1_ready", req1_ready, e1);
            hs = rsp_valid && rsp_ready;
            if (e0 || e1) begin
                o = e0 ? q0.pop_front() : q1.pop_front();
                x.id = e1; x.a = o.a; x.b = o.b; x.err = o.hang;
                x.prod = o.hang ? 64'sd0 : longint'(o.a) * longint'(o.b);
                sb.push_back(x);
                m_idle = 1'b0; m_id = e1; hang_cur = o.hang; n_grant++;
            end
            @(posedge clk); #1;
            if (hs && rst) begin m_idle = 1'b1; m_last = m_id; end
            req0_valid = (q0.size() > 0);
            if (q0.size() > 0) begin req0_a = q0[0].a; req0_b = q0[0].b; end
            req1_valid = (q1.size() > 0);
            if (q1.size() > 0) begin req1_a = q1[0].a; req1_b = q1[0].b; end
            case (rdy_mode)
                0: rsp_ready = 1'b1;
                1: rsp_ready = 1'($urandom_range(0, 1));
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // Response / multiplier-port monitor
    initial begin : monitor
        bit                 prev_valid, prev_hs, prev_start, in_flight;
        bit                 prev_id, prev_err;
        logic [2*WIDTH-1:0] prev_res;
        logic [WIDTH-1:0]   fm, fq;
        int                 cyc, start_cyc;
        exp_t               e;
        prev_valid = 0; prev_hs = 0; prev_start = 0; in_flight = 0; cyc = 0; start_cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                prev_valid = 0; prev_hs = 0; prev_start = 0; in_flight = 0;
                continue;
            end
            if (mul_start) begin
                n_start++;
                chk("mul_start_single_cycle", prev_start, 0);
                if (sb.size() == 0) chk("start_without_grant", 1, 0);
                else begin
                    chk("mul_M", $signed(mul_M), sb[0].a);
                    chk("mul_Q", $signed(mul_Q), sb[0].b);
                end
                in_flight = 1; start_cyc = cyc; fm = mul_M; fq = mul_Q;
            end else if (in_flight && !rsp_valid) begin
                chk("mul_M_stable", mul_M, fm);
                chk("mul_Q_stable", mul_Q, fq);
            end
            prev_start = mul_start;
            if (prev_valid && !prev_hs) chk("rsp_valid_held", rsp_valid, 1);
            if (rsp_valid) begin
                if (!prev_valid || prev_hs) begin
                    in_flight = 0;
                    if (sb.size() > 0 && sb[0].err)
                        chk("timeout_latency", cyc - start_cyc, TIMEOUT_CYC + 1);
                end else begin
                    chk("rsp_id_held", rsp_id, prev_id);
                    chk("rsp_err_held", rsp_err, prev_err);
                    chk("rsp_result_held", rsp_result, prev_res);
                end
                if (rsp_ready) begin
                    if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
                    else begin
                        e = sb.pop_front();
                        chk("rsp_id", rsp_id, e.id);
                        chk("rsp_result", rsp_result, e.prod);
                        chk("rsp_err", rsp_err, e.err);
                    end
                end
            end
            prev_valid = rsp_valid; prev_hs = rsp_valid && rsp_ready;
            prev_id = rsp_id; prev_err = rsp_err; prev_res = rsp_result;
        end
    end

    task automatic do_reset();
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        chk("rst_req0_ready", req0_ready, 0);  chk("rst_req1_ready", req1_ready, 0);
        chk("rst_mul_start", mul_start, 0);    chk("rst_mul_M", mul_M, 0);
        chk("rst_mul_Q", mul_Q, 0);            chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);          chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_err", rsp_err, 0);        chk("rst_busy", busy, 0);
        sb.delete(); m_idle = 1'b1; m_last = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
    endtask

    task automatic drain(input string nm, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (q0.size() == 0 && q1.size() == 0 && sb.size() == 0 && m_idle) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL %s: drain timeout after %0d cycles, %0d responses outstanding", nm, budget, sb.size());
        end
    endtask

    initial begin : main
        int s0;
        bit got;
        int v[5];
        op_t o;
        rst = 1'b0;
        v[0] = 0; v[1] = 1; v[2] = -1; v[3] = 32'sh7fffffff; v[4] = 32'sh80000000;
        do_reset();

        // 1: single op from requester 0
        s0 = n_start;
        q0.push_back('{12345, 6789, 1'b0});
        drain("t1", 200);
        chk("t1_start_pulses", n_start - s0, 1);

        // 2: simultaneous requests right after reset, req0 wins first
        do_reset();
        q0.push_back('{-12345, 6789, 1'b0});
        q1.push_back('{2147483647, -1, 1'b0});
        drain("t2", 300);

        // 3: both held valid over four ops, alternating winners
        s0 = n_start;
        q0.push_back('{32'sh80000000, 32'sh80000000, 1'b0});
        q1.push_back('{12345678, -87654321, 1'b0});
        q0.push_back('{32'sh80000000, 32'sh80000000, 1'b0});
        q1.push_back('{12345678, -87654321, 1'b0});
        drain("t3", 500);
        chk("t3_start_pulses", n_start - s0, 4);

        // 4: back-pressure in RESP; a new request must wait
        rdy_mode = 2;
        q0.push_back('{-7, 9, 1'b0});
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk); #2;
            got = rsp_valid;
        end
        chk("t4_rsp_valid_seen", got, 1);
        q1.push_back('{3, -11, 1'b0});
        repeat (20) @(posedge clk);
        #2 rdy_mode = 0;
        drain("t4", 300);

        // 5: multiplier never completes, then a normal op
        q0.push_back('{111, 222, 1'b1});
        q0.push_back('{-333, 444, 1'b0});
        drain("t5", 400);

        // 6: reset while waiting on the multiplier, then a fresh req1 op
        q1.push_back('{5, 7, 1'b1});
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk); #2;
            got = (n_start > 0) && !m_idle && dut_waiting();
        end
        chk("t6_reached_wait", got, 1);
        repeat (4) @(posedge clk);
        do_reset();
        q1.push_back('{32'sh80000000, 1, 1'b0});
        drain("t6", 300);

        // Randomised traffic with random back-pressure and occasional hangs
        rdy_mode = 1;
        for (int n = 0; n < 40; n++) begin
            o.a = ($urandom_range(0, 3) == 0) ? v[$urandom_range(0, 4)] : int'($urandom);
            o.b = ($urandom_range(0, 3) == 0) ? v[$urandom_range(0, 4)] : int'($urandom);
            o.hang = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 0) q0.push_back(o); else q1.push_back(o);
            repeat ($urandom_range(0, 12)) @(posedge clk);
        end
        drain("random", 8000);
        rdy_mode = 0;

        chk("start_count", n_start, n_grant);
        chk("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Waiting on the multiplier: a start has been issued and no response is up yet.
    function automatic bit dut_waiting();
        return busy && !mul_start && !rsp_valid;
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: simulation did not finish, %0d checks so far", n_chk);
        $fatal(1, "global timeout");
    end

endmodule
